pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 77 +++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and run controller: starts a program on req, sequences the PC
// (increment / relative branch / absolute jump / stall) and raises ack on halt or budget expiry.
module pc_sequencer #(
  parameter int PC_W       = 12,
  parameter int OFF_W      = 8,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             init,
  input  logic             req,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] branch_off,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [PC_W-1:0] off_ext;
  logic [CNT_W:0]  cyc_inc;
  logic            budget_hit;

  assign off_ext    = PC_W'($signed(branch_off));
  // one extra bit so the budget compare cannot alias when cycles is all-ones
  assign cyc_inc    = {1'b0, cycles} + (CNT_W+1)'(1);
  assign budget_hit = (cyc_inc == (CNT_W+1)'(MAX_CYCLES));

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      ack     <= 1'b0;
      timeout <= 1'b0;
      cycles  <= '0;
    end else if (req) begin
      state   <= RUN;
      pc      <= start_addr;
      running <= 1'b1;
      ack     <= 1'b0;
      timeout <= 1'b0;
      cycles  <= '0;
    end else if (state == RUN) begin
      if (halt) begin
        state   <= DONE;
        running <= 1'b0;
        ack     <= 1'b1;
        timeout <= 1'b0;
        cycles  <= cyc_inc[CNT_W-1:0];
      end else if (budget_hit) begin
        state   <= DONE;
        running <= 1'b0;
        ack     <= 1'b1;
        timeout <= 1'b1;
        cycles  <= CNT_W'(MAX_CYCLES);
      end else begin
        cycles <= cyc_inc[CNT_W-1:0];
        if (!stall) begin
          if (jump_en)        pc <= jump_target;
          else if (branch_en) pc <= pc + off_ext;
          else                pc <= pc + PC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer against an integer-arithmetic reference model.
module tb_pc_sequencer;
  localparam int PC_W = 12, OFF_W = 8, CNT_W = 16, MAXC = 16;

  logic clk = 0, init = 0;
  logic req = 0, halt = 0, stall = 0, jump_en = 0, branch_en = 0;
  logic [PC_W-1:0]  start_addr = 0, jump_target = 0;
  logic [OFF_W-1:0] branch_off = 0;
  logic [PC_W-1:0]  pc;
  logic running, ack, timeout;
  logic [CNT_W-1:0] cycles;

  int errors = 0, checks = 0;
  // reference state: mode 0=idle 1=run 2=done
  int m_mode = 0, m_pc = 0, m_cyc = 0, m_to = 0;

  pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .init(init), .req(req), .start_addr(start_addr), .halt(halt), .stall(stall),
    .jump_en(jump_en), .jump_target(jump_target), .branch_en(branch_en), .branch_off(branch_off),
    .pc(pc), .running(running), .ack(ack), .timeout(timeout), .cycles(cycles));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cyc = 0; m_to = 0;
  endtask

  task automatic model_edge();
    int off;
    if (req) begin
      m_mode = 1; m_pc = int'(start_addr); m_cyc = 0; m_to = 0;
    end else if (m_mode == 1) begin
      if (halt) begin
        m_mode = 2; m_cyc++; m_to = 0;
      end else if (m_cyc + 1 == MAXC) begin
        m_mode = 2; m_to = 1; m_cyc = MAXC;
      end else begin
        m_cyc++;
        if (!stall) begin
          off = int'(branch_off);
          if (off >= 128) off -= 256;
          if (jump_en)        m_pc = int'(jump_target);
          else if (branch_en) m_pc = (m_pc + off + 4096) % 4096;
          else                m_pc = (m_pc + 1) % 4096;
        end
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".running"}, 32'(running), 32'(m_mode == 1));
    chk({tag, ".ack"}, 32'(ack), 32'(m_mode == 2));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    chk({tag, ".cycles"}, 32'(cycles), 32'(m_cyc));
  endtask

  task automatic drive(input string tag, input logic r, input int sa, input logic h, input logic s,
                       input logic je, input int jt, input logic be, input int bo);
    req = r; start_addr = PC_W'(sa); halt = h; stall = s;
    jump_en = je; jump_target = PC_W'(jt); branch_en = be; branch_off = OFF_W'(bo);
    @(posedge clk);
    model_edge();
    #1 chk_all(tag);
  endtask

  task automatic nop(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset state
    #2 chk_all("reset");
    #10 init = 1;
    nop("idle");

    // async reset mid-run at pc=0x033
    drive("rst_req", 1, 'h030, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) nop("rst_run");
    chk("rst_pc033", 32'(pc), 32'h033);
    #2 init = 0;
    #1 model_reset(); chk_all("async_rst");
    #1 init = 1;

    // straight-line run 0x010..0x014 then halt
    drive("sl_req", 1, 'h010, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) nop("sl_run");
    drive("sl_halt", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("sl_ack", 32'(ack), 1);
    chk("sl_cycles", 32'(cycles), 5);
    chk("sl_pc", 32'(pc), 32'h014);
    drive("sl_done_ign", 0, 0, 1, 1, 1, 'h333, 1, 3);

    // branches and wrap
    drive("br_req", 1, 'h005, 0, 0, 0, 0, 0, 0);
    drive("br_back", 0, 0, 0, 0, 0, 0, 1, 'hFD);
    chk("br_back_pc", 32'(pc), 32'h002);
    drive("jmp_fff", 0, 0, 0, 0, 1, 'hFFF, 0, 0);
    nop("wrap_inc");
    chk("wrap_pc", 32'(pc), 32'h000);
    nop("inc1");
    drive("br_neg_wrap", 0, 0, 0, 0, 0, 0, 1, 'hFE);
    chk("br_wrap_pc", 32'(pc), 32'hFFF);
    drive("jmp_040", 0, 0, 0, 0, 1, 'h040, 0, 0);
    drive("jmp_vs_br", 0, 0, 0, 0, 1, 'h123, 1, 'h10);
    chk("jmp_wins", 32'(pc), 32'h123);
    drive("br_halt", 0, 0, 1, 0, 0, 0, 0, 0);

    // stall with coincident jump
    drive("st_req", 1, 'h020, 0, 0, 0, 0, 0, 0);
    drive("st_jmp", 0, 0, 0, 1, 1, 'h300, 0, 0);
    drive("st_2", 0, 0, 0, 1, 0, 0, 0, 0);
    drive("st_3", 0, 0, 0, 1, 0, 0, 1, 5);
    chk("st_pc", 32'(pc), 32'h020);
    chk("st_cycles", 32'(cycles), 3);
    nop("st_adv");
    chk("st_adv_pc", 32'(pc), 32'h021);

    // budget timeout
    drive("to_req", 1, 'h000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAXC - 1; i++) nop("to_run");
    chk("to_not_yet", 32'(ack), 0);
    nop("to_edge16");
    chk("to_ack", 32'(ack), 1);
    chk("to_flag", 32'(timeout), 1);
    chk("to_cycles", 32'(cycles), MAXC);
    drive("to_done_ign", 0, 0, 1, 0, 1, 'h111, 0, 0);

    // restart from DONE, halt coincident with budget edge
    drive("to2_req", 1, 'h200, 0, 0, 0, 0, 0, 0);
    chk("done_ack_fall", 32'(ack), 0);
    for (int i = 0; i < MAXC - 1; i++) nop("to2_run");
    drive("to2_halt16", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("to2_flag", 32'(timeout), 0);
    chk("to2_cycles", 32'(cycles), MAXC);

    // mid-run restart and held req
    drive("rs_req", 1, 'h010, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) nop("rs_run");
    drive("rs_restart", 1, 'h080, 0, 0, 0, 0, 0, 0);
    chk("rs_pc", 32'(pc), 32'h080);
    chk("rs_cycles", 32'(cycles), 0);
    drive("rs_hold1", 1, 'h090, 1, 0, 0, 0, 0, 0);
    drive("rs_hold2", 1, 'h0A0, 0, 0, 1, 'h555, 0, 0);
    nop("rs_go");
    chk("rs_go_pc", 32'(pc), 32'h0A1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive("rnd", ($urandom_range(0, 19) == 0), int'($urandom_range(0, 4095)),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4095)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 149) == 0) begin
        #2 init = 0;
        #1 model_reset(); chk_all("rnd_rst");
        #1 init = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
